// File: rtl/booth8_pkg.sv
// Shared constants for the factored radix-8 Booth encoder: canonical {s,d,t,q,n}
// digit codes and the digit-count helper.
package booth8_pkg;

  localparam logic [4:0] CODE_ZERO = 5'b11000;
  localparam logic [4:0] CODE_P1   = 5'b00110;
  localparam logic [4:0] CODE_P2   = 5'b00100;
  localparam logic [4:0] CODE_P3   = 5'b10000;
  localparam logic [4:0] CODE_P4   = 5'b01110;
  localparam logic [4:0] CODE_M1   = 5'b00111;
  localparam logic [4:0] CODE_M2   = 5'b00101;
  localparam logic [4:0] CODE_M3   = 5'b10001;
  localparam logic [4:0] CODE_M4   = 5'b01111;

  // One radix-8 digit per three multiplier bits, rounded up after the implicit x[-1].
  function automatic int num_digits(input int n);
    return (n + 2) / 3;
  endfunction

endpackage

// File: rtl/booth8_digit_enc.sv
// Combinational radix-8 Booth digit encoder: window {x[3i+2],x[3i+1],x[3i],x[3i-1]}
// to its canonical 5-bit {s,d,t,q,n} code.
module booth8_digit_enc
  import booth8_pkg::*;
(
  input  logic [3:0] win,
  output logic [4:0] code
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    code = CODE_ZERO;
    case (win)
      4'b0000, 4'b1111: code = CODE_ZERO;
      4'b0001, 4'b0010: code = CODE_P1;
      4'b0011, 4'b0100: code = CODE_P2;
      4'b0101, 4'b0110: code = CODE_P3;
      4'b0111:          code = CODE_P4;
      4'b1000:          code = CODE_M4;
      4'b1001, 4'b1010: code = CODE_M3;
      4'b1011, 4'b1100: code = CODE_M2;
      4'b1101, 4'b1110: code = CODE_M1;
      default:          code = CODE_ZERO;
    endcase
  end

endmodule

// File: rtl/radix8_booth_encoder.sv
// Radix-8 Booth front-end: registers Y, 3Y and per-digit codes (codes skewed one cycle
// behind Y). Define BOOTH_ENC_SPLIT_ADDER_EN to split the 3Y adder over two cycles.
module radix8_booth_encoder
  import booth8_pkg::*;
#(
  parameter  int N          = 32,
  localparam int NUM_DIGITS = num_digits(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [N-1:0]          X,
  input  logic [N-1:0]          Y,
  output logic [N-1:0]          Y_o,
  output logic [N+1:0]          x3_Y_o,
  output logic [NUM_DIGITS-1:0] s_o,
  output logic [NUM_DIGITS-1:0] d_o,
  output logic [NUM_DIGITS-1:0] t_o,
  output logic [NUM_DIGITS-1:0] q_o,
  output logic [NUM_DIGITS-1:0] n_o,
  output logic                  out_valid
);

  localparam int XW = 3 * NUM_DIGITS + 1;
  localparam logic [NUM_DIGITS-1:0][4:0] ZERO_CODES = {NUM_DIGITS{CODE_ZERO}};

  logic [N-1:0] x_a, y_a;
  logic         valid_a;

  // Stage A: input capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      x_a     <= '0;
      y_a     <= '0;
      valid_a <= 1'b0;
    end else if (en) begin
      x_a     <= X;
      y_a     <= Y;
      valid_a <= in_valid;
    end
  end

  // Operands presented to stage B, plus the finished 3Y.
  logic [N-1:0] x_f, y_f;
  logic         valid_f;
  logic [N+1:0] x3_f;

`ifdef BOOTH_ENC_SPLIT_ADDER_EN
  localparam int LO = N / 2;
  localparam int HI = N + 2 - LO;

  logic [LO-1:0] lo_sum;
  logic          lo_carry;
  logic [N+1:0]  y_ext_f;
  logic [HI-1:0] hi_a, hi_b;

  // Low half of Y + 2Y is registered with its carry; Y and X ride alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_f      <= '0;
      y_f      <= '0;
      valid_f  <= 1'b0;
      lo_sum   <= '0;
      lo_carry <= 1'b0;
    end else if (en) begin
      x_f                  <= x_a;
      y_f                  <= y_a;
      valid_f              <= valid_a;
      {lo_carry, lo_sum}   <= (LO+1)'(y_a[LO-1:0]) + (LO+1)'({y_a[LO-2:0], 1'b0});
    end
  end

  always_comb begin
    y_ext_f = (N+2)'($signed(y_f));
    hi_a    = HI'(y_ext_f >> LO);
    hi_b    = HI'((y_ext_f << 1) >> LO);
    x3_f    = {hi_a + hi_b + HI'(lo_carry), lo_sum};
  end
`else
  logic [N+1:0] y_ext_a;

  always_comb begin
    x_f     = x_a;
    y_f     = y_a;
    valid_f = valid_a;
    y_ext_a = (N+2)'($signed(y_a));
    x3_f    = (y_ext_a << 1) + y_ext_a;
  end
`endif

  // Sign-extended multiplier with the implicit x[-1] = 0 at bit 0.
  logic [XW-1:0]                  x_ext;
  logic [NUM_DIGITS-1:0][4:0]     code_next, code_b, code_c;
  logic                           valid_b;

  assign x_ext = XW'($signed({x_f, 1'b0}));

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    booth8_digit_enc u_enc (
      .win  (x_ext[3*i+3 -: 4]),
      .code (code_next[i])
    );
  end

  // Stage B: Y/3Y hold across bubbles; bubbles load zero-digit codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_o     <= '0;
      x3_Y_o  <= '0;
      code_b  <= ZERO_CODES;
      valid_b <= 1'b0;
    end else if (en) begin
      valid_b <= valid_f;
      if (valid_f) begin
        Y_o    <= y_f;
        x3_Y_o <= x3_f;
        code_b <= code_next;
      end else begin
        code_b <= ZERO_CODES;
      end
    end
  end

  // Stage C: codes one cycle behind Y_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_c    <= ZERO_CODES;
      out_valid <= 1'b0;
    end else if (en) begin
      code_c    <= code_b;
      out_valid <= valid_b;
    end
  end

  always_comb begin
    s_o = '0;
    d_o = '0;
    t_o = '0;
    q_o = '0;
    n_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      {s_o[i], d_o[i], t_o[i], q_o[i], n_o[i]} = code_c[i];
    end
  end

endmodule

// File: tb/tb_radix8_booth_encoder.sv
// Scoreboard bench for radix8_booth_encoder: directed vectors with hand-derived codes,
// reset, stall and latency cases, then a random stream with bubbles and en gaps.
module tb_radix8_booth_encoder;

  localparam int N  = 32;
  localparam int ND = 11;
`ifdef BOOTH_ENC_SPLIT_ADDER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef logic [ND-1:0][4:0] codes_t;
  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    bit           has_codes;
    codes_t       codes;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  X = '0;
  logic [N-1:0]  Y = '0;
  logic [N-1:0]  Y_o;
  logic [N+1:0]  x3_Y_o;
  logic [ND-1:0] s_o, d_o, t_o, q_o, n_o;
  logic          out_valid;

  radix8_booth_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .Y_o       (Y_o),
    .x3_Y_o    (x3_Y_o),
    .s_o       (s_o),
    .d_o       (d_o),
    .t_o       (t_o),
    .q_o       (q_o),
    .n_o       (n_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic codes_t zc();
    codes_t c;
    for (int i = 0; i < ND; i++) c[i] = 5'b11000;
    return c;
  endfunction

  function automatic codes_t cur_codes();
    codes_t c;
    for (int i = 0; i < ND; i++) c[i] = {s_o[i], d_o[i], t_o[i], q_o[i], n_o[i]};
    return c;
  endfunction

  // Independent decode of the canonical code table; ok drops on any non-canonical code.
  function automatic longint decode(input codes_t c, output bit ok);
    longint s;
    int     v;
    s  = 0;
    ok = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      case (c[i])
        5'b11000: v = 0;
        5'b00110: v = 1;
        5'b00100: v = 2;
        5'b10000: v = 3;
        5'b01110: v = 4;
        5'b01111: v = -4;
        5'b10001: v = -3;
        5'b00101: v = -2;
        5'b00111: v = -1;
        default: begin v = 0; ok = 1'b0; end
      endcase
      s = s * 8 + longint'(v);
    end
    return s;
  endfunction

  // Monitor: each enabled edge with out_valid pops one operation; Y_o/x3_Y_o must have
  // carried that operation's values at the previous enabled edge.
  bit           edge_rst = 1'b1;
  bit           edge_en = 1'b0;
  logic [N-1:0] y_prev = '0;
  logic [N+1:0] x3_prev = '0;
  logic         ov_prev = 1'b0;
  codes_t       codes_prev;

  always @(posedge clk) begin
    edge_rst = rst;
    edge_en  = en;
  end

  always @(negedge clk) begin : mon
    codes_t       got;
    exp_t         e;
    bit           ok;
    longint       v, xs;
    logic [N+1:0] x3e;
    got = cur_codes();
    if (!edge_rst) begin
      if (edge_en) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 1'b0, 64'(got), 64'(0));
          end else begin
            e   = sb.pop_front();
            xs  = longint'($signed(e.x));
            x3e = (N+2)'(longint'($signed(e.y)) * 3);
            if (e.has_codes) check("codes", got === e.codes, 64'(got), 64'(e.codes));
            v = decode(got, ok);
            check("digit_sum", ok && (v == xs), 64'(v), 64'(xs));
            check("y_lead", y_prev === e.y, 64'(y_prev), 64'(e.y));
            check("x3_lead", x3_prev === x3e, 64'(x3_prev), 64'(x3e));
          end
        end else begin
          check("bubble_codes", got === zc(), 64'(got), 64'(zc()));
        end
      end else begin
        check("stall_hold", (got === codes_prev) && (Y_o === y_prev) &&
              (x3_Y_o === x3_prev) && (out_valid === ov_prev), 64'(Y_o), 64'(y_prev));
      end
    end
    y_prev     = Y_o;
    x3_prev    = x3_Y_o;
    ov_prev    = out_valid;
    codes_prev = got;
  end

  // Drives one cycle from a negedge; accepted operations go into the scoreboard.
  task automatic drive(input bit v, input bit e, input logic [N-1:0] x, input logic [N-1:0] y,
                       input bit hc, input codes_t c);
    exp_t t;
    in_valid = v;
    en       = e;
    X        = x;
    Y        = y;
    if (v && e && !rst) begin
      t.x         = x;
      t.y         = y;
      t.has_codes = hc;
      t.codes     = c;
      sb.push_back(t);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, '0, 1'b0, zc());
  endtask

  task automatic check_reset();
    check("rst_out_valid", out_valid === 1'b0, 64'(out_valid), 64'(0));
    check("rst_y", Y_o === '0, 64'(Y_o), 64'(0));
    check("rst_x3", x3_Y_o === '0, 64'(x3_Y_o), 64'(0));
    check("rst_codes", cur_codes() === zc(), 64'(cur_codes()), 64'(zc()));
  endtask

  codes_t c;
  int     cnt;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset();
    idle(3);

    // Directed vectors, back to back.
    c = zc(); c[0] = 5'b00111; c[1] = 5'b00110;
    drive(1'b1, 1'b1, 32'd7, 32'd5, 1'b1, c);
    c = zc(); c[0] = 5'b10000;
    drive(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b1, c);
    c = zc(); c[0] = 5'b01111; c[1] = 5'b00110;
    drive(1'b1, 1'b1, 32'd4, 32'd1234, 1'b1, c);
    c = zc();
    drive(1'b1, 1'b1, 32'd0, 32'h8000_0000, 1'b1, c);
    c = zc(); c[10] = 5'b00101;
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, c);
    c = zc(); c[0] = 5'b00111;
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, c);
    c = zc(); c[0] = 5'b00100;
    drive(1'b1, 1'b1, 32'd2, 32'd9, 1'b1, c);
    c = zc(); c[0] = 5'b01111; c[1] = 5'b01110;
    drive(1'b1, 1'b1, 32'd28, 32'd100, 1'b1, c);
    c = zc(); c[1] = 5'b10001; c[2] = 5'b00110;
    drive(1'b1, 1'b1, 32'd40, 32'hFFFF_FF00, 1'b1, c);
    idle(6);

    // Single operation latency, counted in edges after the accepting edge.
    c = zc(); c[0] = 5'b00111; c[1] = 5'b00110;
    drive(1'b1, 1'b1, 32'd7, 32'd5, 1'b1, c);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt == LAT, 64'(cnt), 64'(LAT));
    idle(4);

    // Stall: three back-to-back operations, then en low for two cycles (valid held high).
    c = zc(); c[0] = 5'b10000;
    drive(1'b1, 1'b1, 32'd3, 32'd11, 1'b1, c);
    c = zc(); c[0] = 5'b01111; c[1] = 5'b00110;
    drive(1'b1, 1'b1, 32'd4, 32'd22, 1'b1, c);
    c = zc(); c[0] = 5'b00100;
    drive(1'b1, 1'b1, 32'd2, 32'd33, 1'b1, c);
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, zc());
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, zc());
    idle(6);

    // Reset mid-stream: the two in-flight operations must never emerge.
    drive(1'b1, 1'b1, 32'd7, 32'd5, 1'b0, zc());
    drive(1'b1, 1'b1, 32'd40, 32'd6, 1'b0, zc());
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset();
    idle(6);

    // Random stream with bubbles and en gaps.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rx, ry;
      rx = $urandom();
      ry = $urandom();
      case ($urandom_range(0, 9))
        0: rx = 32'h8000_0000;
        1: rx = 32'hFFFF_FFFF;
        2: ry = 32'h8000_0000;
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, rx, ry, 1'b0, zc());
    end
    idle(8);
    check("drain", sb.size() == 0, 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
